hazard_detect_unit: RTL
=======================

// Module: hazard_detect_unit
// PURPOSE
//  Producer of the 2-bit forwarding selects (rs1_hazard/rs2_hazard) consumed by the EX-stage operand
//  forwarding mux of the 4-stage core. Tracks destination registers of the two in-flight older
//  instructions, compares them against the ID-stage sources, and registers the select for the
//  instruction entering EX. Detects load-use hazards and stalls IF/ID while inserting EX bubbles.
// PARAMETERS
//  ADDR_W          5  register-address width
//  LOAD_USE_STALLS 1  bubbles inserted per load-use hit (>=1)
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  id_valid     in   1       ID stage holds a real instruction
//  id_rs1       in   ADDR_W  ID source register 1
//  id_rs2       in   ADDR_W  ID source register 2
//  id_rs1_used  in   1       instruction reads rs1
//  id_rs2_used  in   1       instruction reads rs2
//  id_rd        in   ADDR_W  ID destination register
//  id_regwrite  in   1       ID instruction writes rd
//  id_memtoreg  in   1       ID instruction is a load
//  flush        in   1       taken branch/jump: kill ID instruction
//  mem_stall    in   1       global freeze (memory wait)
//  rs1_hazard   out  2       EX rs1 select: 00 regfile, 01 result, 10 memtoreg_data
//  rs2_hazard   out  2       EX rs2 select, same encoding
//  stall_if_id  out  1       hold PC and IF/ID register (combinational)
//  ex_valid     out  1       EX holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - State: slot_ex {v,rd,we,ld} = instr now in EX; slot_wb {v,rd,we} = instr one ahead of EX;
//    stall counter cnt (clog2(LOAD_USE_STALLS+1) bits); registered rs1/rs2_hazard, ex_valid.
//  - Reset (async): slots invalid, cnt=0, rs1_hazard=rs2_hazard=00, ex_valid=0.
//  - Match(slot,rsN) = slot.v & slot.we & slot.rd!=0 & rsN_used & slot.rd==rsN. x0 never forwards.
//  - hit = id_valid & !flush & slot_ex.ld & (Match(slot_ex,rs1)|Match(slot_ex,rs2)).
//  - stall_if_id = !flush & (hit | cnt!=0). Combinational, valid same cycle as ID contents.
//  - Select per source at advance: Match(slot_ex) -> 01; else Match(slot_wb) -> 10; else 00.
//    Both match -> 01 (youngest wins). Code 11 never driven.
//  - Edge with mem_stall=1: all state holds (slots, cnt, outputs). Overrides hit/flush.
//  - Edge with mem_stall=0:
//      slot_wb <= slot_ex;
//      if flush | stall_if_id | !id_valid: slot_ex.v<=0, ex_valid<=0, hazards<=00 (bubble)
//      else slot_ex<={1,id_rd,id_regwrite,id_memtoreg}, ex_valid<=1, hazards<=computed selects.
//      cnt: hit & cnt==0 -> LOAD_USE_STALLS-1; cnt!=0 -> cnt-1; flush -> 0 (flush wins).
//  - Latency: selects appear 1 cycle after the ID instruction is accepted, aligned with EX.
//  - Load-use, N=1: one bubble; load then sits in slot_wb and consumer gets 10 (memtoreg_data).
//    N>1: extra bubbles via cnt; selects re-evaluated on release (regfile if load retired).
//  - Reset mid-stall clears cnt and slots; first post-reset instruction sees 00 selects.
// TESTING
//  1 add x5 ; add x6,x5,x1 back-to-back -> cycle consumer in EX: rs1_hazard=01, rs2_hazard=00.
//  2 add x5 ; nop ; sub x7,x1,x5 -> consumer in EX: rs2_hazard=10, rs1_hazard=00.
//  3 add x5 ; add x5 ; or x8,x5,x5 -> both selects 01 (youngest), never 10.
//  4 lw x7 ; add x9,x7,x2 -> stall_if_id=1 one cycle, ex_valid=0 bubble, then rs1_hazard=10;
//    LOAD_USE_STALLS=2 -> two bubbles, stall high two cycles.
//  5 add x0,... ; use x0 -> selects 00; lw x7 hit with flush=1 same cycle -> stall 0, cnt 0, bubble.
//  6 mem_stall=1 for 3 cycles mid load-use -> all outputs frozen; rst asserted mid-stall -> outputs 00/0 immediately.

Source files
------------

// File: rtl/hazard_detect_unit_if.sv
// rtl/hazard_detect_unit_if.sv - ID-stage request and EX forwarding select bundle for hazard_detect_unit
interface hazard_detect_unit_if #(
  parameter int ADDR_W = 5
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [ADDR_W-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memtoreg;
  logic              flush;
  logic              mem_stall;
  logic [1:0]        rs1_hazard;
  logic [1:0]        rs2_hazard;
  logic              stall_if_id;
  logic              ex_valid;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memtoreg, flush, mem_stall,
    input  rs1_hazard, rs2_hazard, stall_if_id, ex_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memtoreg, flush, mem_stall,
    output rs1_hazard, rs2_hazard, stall_if_id, ex_valid
  );
endinterface

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - forwarding select generation and load-use stall for a 4-stage core
module hazard_detect_unit #(
  parameter int ADDR_W          = 5,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_detect_unit_if.slave hz
);

  localparam int              CNT_W      = (LOAD_USE_STALLS < 1) ? 1 : $clog2(LOAD_USE_STALLS + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic              ex_v_q, ex_v_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_ld_q, ex_ld_d;
  logic              wb_v_q, wb_v_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rs1_sel_q, rs1_sel_d;
  logic [1:0]        rs2_sel_q, rs2_sel_d;
  logic              ex_valid_q, ex_valid_d;

  logic m1_ex, m2_ex, m1_wb, m2_wb;
  logic hit, stall, bubble;
  logic [1:0] sel1, sel2;

  // x0 is hardwired zero, so a write to it never produces a forwardable value
  function automatic logic slot_match(input logic v, input logic we,
                                      input logic [ADDR_W-1:0] rd,
                                      input logic used, input logic [ADDR_W-1:0] rs);
    return v & we & (rd != '0) & used & (rd == rs);
  endfunction

  always_comb begin
    m1_ex  = slot_match(ex_v_q, ex_we_q, ex_rd_q, hz.id_rs1_used, hz.id_rs1);
    m2_ex  = slot_match(ex_v_q, ex_we_q, ex_rd_q, hz.id_rs2_used, hz.id_rs2);
    m1_wb  = slot_match(wb_v_q, wb_we_q, wb_rd_q, hz.id_rs1_used, hz.id_rs1);
    m2_wb  = slot_match(wb_v_q, wb_we_q, wb_rd_q, hz.id_rs2_used, hz.id_rs2);
    hit    = hz.id_valid & ~hz.flush & ex_ld_q & (m1_ex | m2_ex);
    stall  = ~hz.flush & (hit | (cnt_q != '0));
    bubble = hz.flush | stall | ~hz.id_valid;
    sel1   = m1_ex ? SEL_EX : (m1_wb ? SEL_MEM : SEL_RF);
    sel2   = m2_ex ? SEL_EX : (m2_wb ? SEL_MEM : SEL_RF);
  end

  always_comb begin
    ex_v_d     = ex_v_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    ex_ld_d    = ex_ld_q;
    wb_v_d     = wb_v_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    cnt_d      = cnt_q;
    rs1_sel_d  = rs1_sel_q;
    rs2_sel_d  = rs2_sel_q;
    ex_valid_d = ex_valid_q;
    // mem_stall freezes every piece of state, taking priority over hit and flush
    if (!hz.mem_stall) begin
      wb_v_d  = ex_v_q;
      wb_rd_d = ex_rd_q;
      wb_we_d = ex_we_q;
      if (bubble) begin
        ex_v_d     = 1'b0;
        ex_valid_d = 1'b0;
        rs1_sel_d  = SEL_RF;
        rs2_sel_d  = SEL_RF;
      end else begin
        ex_v_d     = 1'b1;
        ex_rd_d    = hz.id_rd;
        ex_we_d    = hz.id_regwrite;
        ex_ld_d    = hz.id_memtoreg;
        ex_valid_d = 1'b1;
        rs1_sel_d  = sel1;
        rs2_sel_d  = sel2;
      end
      if (hz.flush)
        cnt_d = '0;
      else if (cnt_q != '0)
        cnt_d = cnt_q - CNT_ONE;
      else if (hit)
        cnt_d = CNT_RELOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q     <= 1'b0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      cnt_q      <= '0;
      rs1_sel_q  <= SEL_RF;
      rs2_sel_q  <= SEL_RF;
      ex_valid_q <= 1'b0;
    end else begin
      ex_v_q     <= ex_v_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      ex_ld_q    <= ex_ld_d;
      wb_v_q     <= wb_v_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      cnt_q      <= cnt_d;
      rs1_sel_q  <= rs1_sel_d;
      rs2_sel_q  <= rs2_sel_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign hz.rs1_hazard  = rs1_sel_q;
  assign hz.rs2_hazard  = rs2_sel_q;
  assign hz.ex_valid    = ex_valid_q;
  assign hz.stall_if_id = stall;

endmodule
